wb_camera_dma: RTL and testbench
================================

# wb_camera_dma

Parametrised successor to `wb_camera_if`: captures a parallel camera stream that has already been sampled into the system clock domain and writes each frame to memory through a Wishbone master. Adds several things the previous block lacked: configurable pixel and bus width with lane packing, optional 2x2 decimation, an internal elastic FIFO with a sticky overrun flag, and per-frame header and trailer words. It sits between the camera pin interface and the SoC Wishbone interconnect.

## Interface
Parameters:
- `ADR_WIDTH`, 10: Wishbone word-address width.
- `DAT_WIDTH`, 32: Wishbone data width. Must be a multiple of `PIX_WIDTH`.
- `PIX_WIDTH`, 8: bits per pixel.
- `COLS`, 16: maximum pixels per line.
- `ROWS`, 12: maximum lines per frame.
- `FIFO_DEPTH`, 8: packed-word FIFO depth. Power of two, at least 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `pix_vld` in 1: pixel strobe, qualifies `pixel_dat`.
- `pixel_dat` in `PIX_WIDTH`: pixel data.
- `frame_vld` in 1: frame valid.
- `line_vld` in 1: line valid.
- `enable` in 1: arm capture. Sampled only at frame start.
- `decimate` in 1: 2x2 subsample. Sampled only at frame start.
- `wr_addr_start` in `ADR_WIDTH`: header word address.
- `timestamp` in `DAT_WIDTH`: captured at frame start.
- `overrun_clr` in 1: clears `overrun`.
- `m_wb_cyc`, `m_wb_stb`, `m_wb_we` out 1: Wishbone master controls. `m_wb_we` is always 1.
- `m_wb_adr` out `ADR_WIDTH`: Wishbone address.
- `m_o_wb_dat` out `DAT_WIDTH`: Wishbone write data.
- `m_wb_ack` in 1: Wishbone acknowledge.
- `num_cols` out `$clog2(COLS)+1`: raw pixel count of the last line.
- `num_rows` out `$clog2(ROWS)+1`: raw line count of the last frame.
- `overrun` out 1: sticky FIFO-full drop flag.
- `frame_done` out 1: one-cycle pulse at frame completion.
- `busy` out 1: FSM is not in IDLE.

## Operation
- **Frame start:** `frame_vld` is 1 now and was 0 on the previous cycle.
  - If the FSM is in IDLE and `enable`=1, latch `timestamp`, `decimate` and `wr_addr_start`, then go to HDR.
  - Otherwise the frame is ignored entirely.
- **Accepted pixels:** a pixel is accepted when `pix_vld & line_vld & frame_vld` and the frame was armed.
  - With decimation on, only even column and even row indices (counting from 0) are kept.
- **Packing:** `K = DAT_WIDTH/PIX_WIDTH` pixels per word. The first pixel goes in bits `[PIX_WIDTH-1:0]`.
  - On a `line_vld` falling edge, a partial word is flushed with its unused upper lanes zeroed.
  - A word is pushed to the FIFO when the K-th pixel is accepted or on a flush.
  - Push while the FIFO is full: the word is dropped, `overrun` is set, and capture continues.
- **FSM states:**
  - IDLE.
  - HDR: write the latched timestamp at `wr_addr_start`.
  - DATA: pop the FIFO and write at addresses `wr_addr_start+1`, `+2`, and so on.
  - TRL: entered when `frame_vld` has fallen, the packer is empty and the FIFO is empty. Writes `{num_rows, num_cols}`, zero-extended into `[31:16]` and `[15:0]`, at the next address.
  - Completion of TRL pulses `frame_done` and returns to IDLE.
- **Addresses** wrap modulo `2^ADR_WIDTH`.
- **Counters:** `num_cols` and `num_rows` count raw input, not decimated output, and saturate at their maximum.
  - `num_cols` updates on each `line_vld` fall.
  - `num_rows` updates at frame end.
- **`overrun_clr` vs new overrun:** if `overrun_clr` and a new overrun occur in the same cycle, set wins.

## Timing
- **Reset values:** all outputs are 0; the FIFO and packer are emptied.
- **Reset mid-transaction:** `rst` abandons any transaction, and `m_wb_cyc`/`m_wb_stb` are low on the cycle after `rst` is sampled high.
- **Classic Wishbone:**
  - `m_wb_cyc` equals `m_wb_stb`.
  - `m_wb_adr` and `m_o_wb_dat` stay stable until `m_wb_ack`.
  - Back-to-back beats are allowed: `m_wb_stb` stays high after an ack when the next word is ready.
- **Latency from frame start:** if the frame-start cycle is N, `m_wb_stb` is high with the header at N+1.
- **Latency from packing:** a word completed at cycle P is visible in the FIFO at P+1 and can be on the bus at P+2 at the earliest.
- **Throughput:** with ack held high, one word per cycle.
- **Trailer:** TRL is entered the cycle after the empty condition holds. `frame_done` pulses in the cycle after the trailer's ack.
- **Ignored input:** a frame start while the FSM is not in IDLE is ignored (no restart).

## Structure
- **Shared package `camera_pkg`:** FSM state enum (IDLE, HDR, DATA, TRL) and the header/trailer field offsets.
- **Sub-module `sync_fifo`:** parametrised width and depth, first-word fall-through, with `full`/`empty` outputs. It is also reusable elsewhere.

## Test plan
- **Full frame:** defaults, `wr_addr_start`=0x100, `timestamp`=0xdeadbabe, 16x12 incrementing frame, `m_wb_ack`=`cyc&stb`.
  - Header 0xdeadbabe at 0x100.
  - 48 pixel words at 0x101–0x130; the first is 0x03020100.
  - Trailer 0x000c0010 at 0x131, then `frame_done`.
  - `num_rows`=12, `num_cols`=16.
- **Decimation:** `decimate`=1, same frame.
  - 12 words at 0x101–0x10C; the first is 0x06040200.
  - Trailer at 0x10D with 0x000c0010.
- **Partial line:** lines of 15 pixels.
  - Every 4th word has its top byte equal to 0x00.
  - `num_cols`=15; 48 data words.
- **Overrun:** ack held low for 200 cycles during a frame.
  - `overrun`=1, and fewer than 48 data words are written.
  - The frame still ends with a trailer.
  - `overrun_clr` returns `overrun` to 0.
- **Address wrap:** `wr_addr_start`=0x3FF gives the header at 0x3FF and the first data word at 0x000.
- **Disarm and reset:**
  - `enable`=0 at frame start: no bus activity.
  - `rst` mid-DATA: `cyc` is low the next cycle, the FSM is in IDLE, and the next frame captures correctly.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types for the camera DMA: FSM state encoding and trailer field placement.
package camera_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_TRL} state_e;
  localparam int TRL_ROWS_LSB = 16;
  localparam int TRL_COLS_LSB = 0;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head whenever !empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk)
    if (push && !full) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/wb_camera_dma.sv
// Camera frame capture to Wishbone: packs pixels into bus words, buffers them,
// and writes header (timestamp), pixel words and a {rows, cols} trailer per frame.
module wb_camera_dma
  import camera_pkg::*;
#(
  parameter int ADR_WIDTH  = 10,
  parameter int DAT_WIDTH  = 32,
  parameter int PIX_WIDTH  = 8,
  parameter int COLS       = 16,
  parameter int ROWS       = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_vld,
  input  logic [PIX_WIDTH-1:0]       pixel_dat,
  input  logic                       frame_vld,
  input  logic                       line_vld,
  input  logic                       enable,
  input  logic                       decimate,
  input  logic [ADR_WIDTH-1:0]       wr_addr_start,
  input  logic [DAT_WIDTH-1:0]       timestamp,
  input  logic                       overrun_clr,
  output logic                       m_wb_cyc,
  output logic                       m_wb_stb,
  output logic                       m_wb_we,
  output logic [ADR_WIDTH-1:0]       m_wb_adr,
  output logic [DAT_WIDTH-1:0]       m_o_wb_dat,
  input  logic                       m_wb_ack,
  output logic [$clog2(COLS):0]      num_cols,
  output logic [$clog2(ROWS):0]      num_rows,
  output logic                       overrun,
  output logic                       frame_done,
  output logic                       busy
);
  localparam int K  = DAT_WIDTH / PIX_WIDTH;
  localparam int LW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = $clog2(COLS) + 1;
  localparam int RW = $clog2(ROWS) + 1;

  state_e                          state;
  logic                            fv_q, lv_q, armed, dec_q;
  logic [CW-1:0]                   col_cnt;
  logic [RW-1:0]                   row_cnt, row_inc;
  logic [K-1:0][PIX_WIDTH-1:0]     pk, push_word;
  logic [LW-1:0]                   lane;
  logic [ADR_WIDTH-1:0]            nxt_adr;
  logic [DAT_WIDTH-1:0]            trl_word, fifo_dout;
  logic frame_start, frame_fall, line_fall, arm, raw_pix, keep, lane_last;
  logic push, pop, free, fifo_full, fifo_empty, frame_end;

  assign frame_start = frame_vld & ~fv_q;
  assign frame_fall  = ~frame_vld & fv_q;
  assign line_fall   = ~line_vld & lv_q;
  assign arm         = frame_start & enable & (state == ST_IDLE);
  assign raw_pix     = pix_vld & line_vld & frame_vld & armed;
  assign keep        = raw_pix & (~dec_q | (~col_cnt[0] & ~row_cnt[0]));
  assign lane_last   = (lane == LW'(K-1));
  assign push        = (keep & lane_last) | (armed & line_fall & (lane != '0));
  assign row_inc     = (row_cnt == '1) ? row_cnt : row_cnt + RW'(1);

  // The K-th pixel goes straight into the pushed word, not via the lane register.
  always_comb begin
    push_word = pk;
    if (keep) push_word[lane] = pixel_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q <= 1'b0; lv_q <= 1'b0; armed <= 1'b0; dec_q <= 1'b0;
      col_cnt <= '0; row_cnt <= '0; lane <= '0; pk <= '0;
      num_cols <= '0; num_rows <= '0; overrun <= 1'b0;
    end else begin
      fv_q <= frame_vld;
      lv_q <= line_vld;
      if (push && fifo_full)  overrun <= 1'b1;
      else if (overrun_clr)   overrun <= 1'b0;
      if (arm) begin
        armed <= 1'b1; dec_q <= decimate;
        col_cnt <= '0; row_cnt <= '0; lane <= '0; pk <= '0;
      end else if (armed) begin
        if (raw_pix && col_cnt != '1) col_cnt <= col_cnt + CW'(1);
        if (keep) begin
          if (lane_last) begin
            lane <= '0; pk <= '0;
          end else begin
            pk[lane] <= pixel_dat; lane <= lane + LW'(1);
          end
        end
        if (line_fall) begin
          num_cols <= col_cnt; col_cnt <= '0; row_cnt <= row_inc;
          lane <= '0; pk <= '0;
        end
        if (frame_fall) begin
          armed    <= 1'b0;
          num_rows <= line_fall ? row_inc : row_cnt;
        end
      end
    end
  end

  sync_fifo #(.WIDTH(DAT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(push_word), .pop(pop),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  always_comb begin
    trl_word = '0;
    trl_word[TRL_ROWS_LSB +: RW] = num_rows;
    trl_word[TRL_COLS_LSB +: CW] = num_cols;
  end

  assign free      = ~m_wb_stb | m_wb_ack;
  assign pop       = ((state == ST_HDR) || (state == ST_DATA)) & free & ~fifo_empty;
  assign frame_end = ~armed & (lane == '0) & fifo_empty;
  assign m_wb_cyc  = m_wb_stb;
  assign m_wb_we   = 1'b1;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE; m_wb_stb <= 1'b0; m_wb_adr <= '0;
      m_o_wb_dat <= '0; nxt_adr <= '0; frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (arm) begin
          m_wb_adr   <= wr_addr_start;
          m_o_wb_dat <= timestamp;
          m_wb_stb   <= 1'b1;
          nxt_adr    <= wr_addr_start + ADR_WIDTH'(1);
          state      <= ST_HDR;
        end
        ST_HDR, ST_DATA: if (free) begin
          state <= ST_DATA;
          if (!fifo_empty) begin
            m_wb_adr <= nxt_adr; m_o_wb_dat <= fifo_dout; m_wb_stb <= 1'b1;
            nxt_adr  <= nxt_adr + ADR_WIDTH'(1);
          end else if (frame_end) begin
            m_wb_adr <= nxt_adr; m_o_wb_dat <= trl_word; m_wb_stb <= 1'b1;
            state    <= ST_TRL;
          end else begin
            m_wb_stb <= 1'b0;
          end
        end
        ST_TRL: if (m_wb_ack) begin
          m_wb_stb <= 1'b0; frame_done <= 1'b1; state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_camera_dma.sv
// Randomized bench for wb_camera_dma: frame-level model of expected bus writes,
// per-cycle protocol checks and frame checks in one compare process.
module tb_wb_camera_dma;
  localparam int AW = 10, DW = 32, PW = 8, COLS = 16, ROWS = 12, FD = 8;

  logic clk = 1'b0, rst;
  logic pix_vld, frame_vld, line_vld, enable, decimate, overrun_clr;
  logic [PW-1:0] pixel_dat;
  logic [AW-1:0] wr_addr_start, m_wb_adr;
  logic [DW-1:0] timestamp, m_o_wb_dat;
  logic m_wb_cyc, m_wb_stb, m_wb_we, m_wb_ack, overrun, frame_done, busy;
  logic [$clog2(COLS):0] num_cols;
  logic [$clog2(ROWS):0] num_rows;
  logic ack_gate = 1'b0;
  int   ack_mode = 0;

  always #5 clk = ~clk;
  assign m_wb_ack = m_wb_cyc & m_wb_stb & ack_gate;

  wb_camera_dma #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .PIX_WIDTH(PW), .COLS(COLS),
                  .ROWS(ROWS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .pix_vld(pix_vld), .pixel_dat(pixel_dat),
    .frame_vld(frame_vld), .line_vld(line_vld), .enable(enable), .decimate(decimate),
    .wr_addr_start(wr_addr_start), .timestamp(timestamp), .overrun_clr(overrun_clr),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we), .m_wb_adr(m_wb_adr),
    .m_o_wb_dat(m_o_wb_dat), .m_wb_ack(m_wb_ack), .num_cols(num_cols),
    .num_rows(num_rows), .overrun(overrun), .frame_done(frame_done), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  logic [PW-1:0] pix [ROWS][COLS];
  logic [DW-1:0] exp_words[$];
  logic [AW-1:0] exp_hdr_adr;
  logic [DW-1:0] exp_ts, exp_trl;
  bit            lossy;
  logic [AW-1:0] got_adr[$];
  logic [DW-1:0] got_dat[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ack_mode)
      0: ack_gate = 1'b1;
      1: ack_gate = ($urandom_range(3) != 0);
      default: ack_gate = 1'b0;
    endcase
  end

  // Expected pixel words: kept pixels of each line, packed 4 per word, low lane first.
  task automatic build_model(input int rows, input int cols, input bit dec);
    exp_words.delete();
    for (int r = 0; r < rows; r++) begin
      logic [DW-1:0] w;
      int n;
      if (dec && (r % 2) != 0) continue;
      w = '0; n = 0;
      for (int c = 0; c < cols; c++) begin
        if (dec && (c % 2) != 0) continue;
        w = w | (DW'(pix[r][c]) << (PW * n));
        n++;
        if (n == DW / PW) begin exp_words.push_back(w); w = '0; n = 0; end
      end
      if (n > 0) exp_words.push_back(w);
    end
    exp_trl = (DW'(rows) << 16) | DW'(cols);
  endtask

  task automatic prep_frame(input int rows, input int cols, input bit dec,
                            input bit rnd, input bit lsy);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pix[r][c] = rnd ? PW'($urandom) : PW'(r * cols + c);
    decimate = dec; enable = 1'b1; lossy = lsy;
    exp_hdr_adr = wr_addr_start; exp_ts = timestamp;
    build_model(rows, cols, dec);
    got_adr.delete(); got_dat.delete();
  endtask

  task automatic run_frame(input int rows, input int cols, input int gap, input int rst_row);
    frame_vld = 1'b1; tick; repeat (2) tick;
    for (int r = 0; r < rows; r++) begin
      int c = 0;
      line_vld = 1'b1;
      while (c < cols) begin
        if (int'($urandom_range(99)) < gap) begin
          pix_vld = 1'b0; pixel_dat = PW'($urandom);
        end else begin
          pix_vld = 1'b1; pixel_dat = pix[r][c]; c++;
        end
        tick;
      end
      pix_vld = 1'b0; line_vld = 1'b0; tick;
      if (r == rst_row) begin
        chk("busy_before_rst", busy, 1);
        rst = 1'b1; tick; rst = 1'b0; frame_vld = 1'b0;
        @(negedge clk);
        chk("cyc_after_rst", m_wb_cyc, 0);
        chk("busy_after_rst", busy, 0);
        return;
      end
      repeat (6) tick;
    end
    frame_vld = 1'b0; tick; repeat (2) tick;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin tick; t++; end
    chk("frame_done_seen", 64'(done_cnt != d0), 1);
    repeat (2) tick;
  endtask

  task automatic check_frame;
    int n = got_dat.size();
    logic [AW-1:0] a;
    if (n < 2) begin
      chk("frame_beats_min2", 64'(n), 2);
      return;
    end
    chk("hdr_adr", got_adr[0], exp_hdr_adr);
    chk("hdr_dat", got_dat[0], exp_ts);
    a = exp_hdr_adr + AW'(n - 1);
    chk("trl_adr", got_adr[n-1], a);
    chk("trl_dat", got_dat[n-1], exp_trl);
    for (int i = 1; i < n - 1; i++) begin
      a = exp_hdr_adr + AW'(i);
      chk("data_adr", got_adr[i], a);
    end
    if (!lossy) begin
      chk("data_count", 64'(n - 2), 64'(exp_words.size()));
      for (int i = 1; i < n - 1; i++)
        if (i - 1 < exp_words.size()) chk("data_word", got_dat[i], exp_words[i-1]);
    end else begin
      int j = 0;
      for (int i = 1; i < n - 1; i++) begin
        while (j < exp_words.size() && exp_words[j] != got_dat[i]) j++;
        chk("data_in_order", 64'(j < exp_words.size()), 1);
        j++;
      end
      chk("some_dropped", 64'(n - 2 < exp_words.size()), 1);
    end
  endtask

  logic          pend = 1'b0, done_q = 1'b0;
  logic [AW-1:0] pend_adr;
  logic [DW-1:0] pend_dat;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0; done_q = 1'b0;
    end else begin
      chk("cyc_eq_stb", m_wb_cyc, m_wb_stb);
      chk("we_high", m_wb_we, 1);
      if (pend && m_wb_stb) begin
        chk("adr_stable", m_wb_adr, pend_adr);
        chk("dat_stable", m_o_wb_dat, pend_dat);
      end
      pend = m_wb_stb && !m_wb_ack; pend_adr = m_wb_adr; pend_dat = m_o_wb_dat;
      if (m_wb_cyc && m_wb_stb && m_wb_ack) begin
        got_adr.push_back(m_wb_adr); got_dat.push_back(m_o_wb_dat);
      end
      if (frame_done && done_q) chk("done_one_cycle", 0, 1);
      if (frame_done) begin check_frame(); done_cnt++; end
      done_q = frame_done;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, sz;
    rst = 1'b1; pix_vld = 0; pixel_dat = 0; frame_vld = 0; line_vld = 0;
    enable = 0; decimate = 0; wr_addr_start = 0; timestamp = 0; overrun_clr = 0;
    repeat (3) tick;
    @(negedge clk);
    chk("rst_cyc", m_wb_cyc, 0); chk("rst_stb", m_wb_stb, 0);
    chk("rst_adr", m_wb_adr, 0); chk("rst_dat", m_o_wb_dat, 0);
    chk("rst_cols", num_cols, 0); chk("rst_rows", num_rows, 0);
    chk("rst_ovr", overrun, 0); chk("rst_done", frame_done, 0); chk("rst_busy", busy, 0);
    tick; rst = 1'b0; repeat (2) tick;

    // full frame, incrementing pixels
    ack_mode = 0; wr_addr_start = 10'h100; timestamp = 32'hdeadbabe;
    prep_frame(12, 16, 0, 0, 0); d0 = done_cnt;
    run_frame(12, 16, 0, -1); wait_done(d0);
    sz = got_dat.size();
    chk("full_beats", 64'(sz), 50);
    if (sz == 50) begin
      chk("full_hdr_adr", got_adr[0], 10'h100); chk("full_hdr", got_dat[0], 32'hdeadbabe);
      chk("full_first", got_dat[1], 32'h03020100);
      chk("full_trl_adr", got_adr[49], 10'h131); chk("full_trl", got_dat[49], 32'h000c0010);
    end
    chk("full_rows", num_rows, 12); chk("full_cols", num_cols, 16); chk("idle_busy", busy, 0);

    // 2x2 decimation
    prep_frame(12, 16, 1, 0, 0); d0 = done_cnt;
    run_frame(12, 16, 0, -1); wait_done(d0);
    sz = got_dat.size();
    chk("dec_beats", 64'(sz), 14);
    if (sz == 14) begin
      chk("dec_first", got_dat[1], 32'h06040200);
      chk("dec_trl_adr", got_adr[13], 10'h10d); chk("dec_trl", got_dat[13], 32'h000c0010);
    end

    // 15-pixel lines
    prep_frame(12, 15, 0, 0, 0); d0 = done_cnt;
    run_frame(12, 15, 0, -1); wait_done(d0);
    sz = got_dat.size();
    chk("part_beats", 64'(sz), 50);
    if (sz == 50) for (int i = 4; i <= 48; i += 4) chk("part_top_byte", got_dat[i][31:24], 0);
    chk("part_cols", num_cols, 15);

    // random frames, random gaps and ack stalls
    ack_mode = 1;
    for (int it = 0; it < 5; it++) begin
      int rr = $urandom_range(12, 2), cc = $urandom_range(16, 1);
      wr_addr_start = AW'($urandom); timestamp = $urandom;
      prep_frame(rr, cc, 1'($urandom_range(1)), 1, 0); d0 = done_cnt;
      run_frame(rr, cc, 30, -1); wait_done(d0);
      chk("rnd_rows", num_rows, rr); chk("rnd_cols", num_cols, cc);
    end

    // overrun: ack held low for 200 cycles
    wr_addr_start = 10'h100; timestamp = 32'h12345678;
    prep_frame(12, 16, 0, 0, 1); d0 = done_cnt; ack_mode = 2;
    fork
      run_frame(12, 16, 0, -1);
      begin repeat (200) tick; ack_mode = 0; end
    join
    wait_done(d0);
    chk("ovr_set", overrun, 1);
    chk("ovr_fewer_words", 64'(got_dat.size() < 50), 1);
    overrun_clr = 1'b1; tick; overrun_clr = 1'b0;
    @(negedge clk); chk("ovr_clr", overrun, 0);

    // address wrap
    wr_addr_start = 10'h3ff; timestamp = $urandom;
    prep_frame(3, 8, 0, 1, 0); d0 = done_cnt;
    run_frame(3, 8, 10, -1); wait_done(d0);
    if (got_adr.size() >= 2) begin
      chk("wrap_hdr_adr", got_adr[0], 10'h3ff); chk("wrap_first_adr", got_adr[1], 10'h000);
    end else chk("wrap_beats", 64'(got_adr.size()), 8);

    // disarmed frame
    prep_frame(4, 8, 0, 1, 0); enable = 1'b0; d0 = done_cnt;
    run_frame(4, 8, 0, -1); repeat (20) tick;
    chk("disarm_beats", 64'(got_dat.size()), 0);
    chk("disarm_done", 64'(done_cnt), 64'(d0)); chk("disarm_busy", busy, 0);

    // reset mid-DATA, then a clean frame
    wr_addr_start = 10'h200; timestamp = 32'hcafef00d;
    prep_frame(12, 16, 0, 0, 0); d0 = done_cnt;
    run_frame(12, 16, 0, 4); repeat (20) tick;
    chk("rst_no_done", 64'(done_cnt), 64'(d0));
    prep_frame(12, 16, 0, 0, 0); d0 = done_cnt;
    run_frame(12, 16, 0, -1); wait_done(d0);
    chk("post_rst_beats", 64'(got_dat.size()), 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
